i2c_wire_master: RTL and testbench
==================================

# i2c_wire_master

Byte-level I2C initiator that turns FrontPanel wire-in endpoint values into a single I2C bus transaction and returns status and read data through a wire-out endpoint. It sits between the okWireIn/okWireOut endpoints and the board `i2c_scl`/`i2c_sda` pads, which it drives open-drain. Once this block is instantiated, those pads stop being tied to high-impedance. Each transaction is START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.

## Interface
- `CLK_DIV`, default 120: `ti_clk` cycles per quarter bit. One SCL period is 4·`CLK_DIV` cycles, which gives 100 kHz at 48 MHz. Legal range is 2..1023.
- `ti_clk`  in  1: single clock, all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cmd_go`  in  1: level from a wire-in. A 0→1 edge requests a transaction.
- `cmd_rw`  in  1: 0 = write, 1 = read. Captured on an accepted edge.
- `cmd_addr`  in  7: target address. Captured on an accepted edge.
- `cmd_wdata`  in  8: write byte. Captured on an accepted edge.
- `sda_in`  in  1: SDA pad input, asynchronous.
- `sda_oe`  out  1: 1 = pull SDA low, 0 = release.
- `scl_oe`  out  1: 1 = pull SCL low, 0 = release.
- `busy`  out  1: transaction in progress.
- `done`  out  1: sticky. Set when a transaction completes, cleared by the next accepted edge.
- `ack_err`  out  1: sticky. Set on address or write-data NACK, cleared by the next accepted edge.
- `rdata`  out  8: last byte read. Holds its value until the next read completes.

## Operation
- Edge detection
  - Register `cmd_go` once. An edge is `cmd_go & ~go_q`.
  - An edge is accepted only in IDLE. Edges while `busy` are ignored and not queued.
- Input synchronisation: pass `sda_in` through a 2-flop synchroniser. All sampling uses the synchronised value.
- Bit timing
  - A quarter counter counts 0..`CLK_DIV`-1. Each wrap advances the phase q0→q1→q2→q3.
  - Each bit slot is the four phases q0..q3.
- Data bit (transmit or receive)
  - q0: SCL low; `sda_oe` updated at q0 entry.
  - q1, q2: SCL released.
  - q3: SCL low.
  - Sample SDA on the last cycle of q1.
- START slot
  - q0, q1: SDA and SCL released.
  - q2: SDA low.
  - q3: SCL low.
- STOP slot
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2, q3: both released.
- State machine and transitions
  - IDLE → START on an accepted edge. Capture shift = {`cmd_addr`,`cmd_rw`}; clear `done` and `ack_err`.
  - START → ADDR: 8 slots, MSB first.
  - ADDR → AACK: 1 slot, SDA released.
    - Sample 1 (NACK): set `ack_err`, go to STOP.
    - Otherwise go to DATA.
  - DATA: 8 slots.
    - Write: drive `cmd_wdata` MSB first.
    - Read: SDA released, shift sampled bits in MSB first.
  - DATA → DACK.
    - Write: SDA released; a sampled 1 sets `ack_err`.
    - Read: master drives NACK, i.e. SDA released.
    - Then go to STOP.
  - STOP → IDLE. On the transition, set `done`. For a read without address NACK, also load `rdata`.
- Output drive: outputs are driven only by pulling low or releasing. The block never drives high.
- No clock-stretching support. SCL is not read back.

## Timing
- Reset values: `sda_oe`=0, `scl_oe`=0, `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, state IDLE, counters 0.
  - Reset asserted mid-transaction releases both lines immediately (asynchronous).
  - No STOP is generated in that case.
- `busy` rises 2 cycles after `cmd_go` rises: edge register, then state register.
- Slot counts
  - Full transaction: 20 slots (1+8+1+8+1+1) = 80·`CLK_DIV` cycles from START entry to IDLE.
  - Address NACK: 11 slots (START+8+AACK+STOP) = 44·`CLK_DIV` cycles.
- `done`, `rdata` and `busy`=0 all update on the same cycle as STOP→IDLE.
- `ack_err` updates at the sample point of the failing ACK.
- `cmd_*` may change freely while `busy`. Only the values captured at acceptance are used.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Write, ACK (`CLK_DIV`=4, `cmd_addr`=7'h50, `cmd_rw`=0, `cmd_wdata`=8'hA5; bus model ACKs everything)
  - Bus monitor decodes START, 8'hA0, ACK, 8'hA5, ACK, STOP.
  - `done`=1, `ack_err`=0, `busy` high for exactly 320 cycles.
- Read (addr 7'h50, `cmd_rw`=1; model returns 8'h3C)
  - Monitor sees 8'hA1, ACK, data 8'h3C, master NACK, STOP.
  - `rdata`=8'h3C, `done`=1.
- Address NACK (model never ACKs)
  - START, address byte, NACK, STOP.
  - `ack_err`=1, `done`=1, `busy` high 176 cycles, `rdata` unchanged.
- Go while busy: second `cmd_go` 0→1 edge mid-transaction → ignored. Exactly one transaction occurs; `done` sets once.
- Level hold: `cmd_go` held at 1 after completion → no new transaction. Dropping to 0 and back to 1 starts one, and `done`/`ack_err` clear 2 cycles after the edge.
- Reset mid-operation: assert `reset_n`=0 during DATA → `sda_oe`=`scl_oe`=0 in the same cycle, all status outputs at reset values. A new transaction works after release.

Source files
------------

// File: rtl/i2c_wire_master.sv
// Byte-level I2C initiator: one START/addr/ACK/data/ACK/STOP transaction per
// cmd_go rising edge, driving SCL/SDA open-drain and reporting sticky status.
module i2c_wire_master #(
    parameter int unsigned CLK_DIV = 120
) (
    input  logic       ti_clk,
    input  logic       reset_n,
    input  logic       cmd_go,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    localparam int unsigned QW = 10;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [QW-1:0] r_qcnt, w_qcnt_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_wdata, w_wdata_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_nack, w_nack_nxt;
    logic          r_done, w_done_nxt;
    logic          r_ack_err, w_ack_err_nxt;
    logic [7:0]    r_rdata, w_rdata_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_sda_oe, w_sda_oe_nxt;
    logic          r_scl_oe, w_scl_oe_nxt;
    logic          r_go_q, r_go_edge;
    logic          r_sda_s1, r_sda_s2;
    logic          w_q_wrap, w_sample, w_slot_end;
    logic [1:0]    w_drive;

    // Line drive for a given state/phase: returns {scl_oe, sda_oe}.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph,
                                              input logic bit_lo, input logic rd);
        logic scl_low;
        scl_low = (ph == 2'd0) || (ph == 2'd3);
        case (st)
            S_START: line_drive = {ph == 2'd3, ph[1]};
            S_ADDR:  line_drive = {scl_low, bit_lo};
            S_AACK:  line_drive = {scl_low, 1'b0};
            S_DATA:  line_drive = {scl_low, bit_lo & ~rd};
            S_DACK:  line_drive = {scl_low, 1'b0};
            S_STOP:  line_drive = {ph == 2'd0, ~ph[1]};
            default: line_drive = 2'b00;
        endcase
    endfunction

    assign w_q_wrap   = (r_qcnt == Q_LAST);
    assign w_sample   = w_q_wrap && (r_phase == 2'd1);
    assign w_slot_end = w_q_wrap && (r_phase == 2'd3);

    // Command edge detect (registered pulse) and SDA 2-flop synchroniser.
    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go_q    <= 1'b0;
            r_go_edge <= 1'b0;
            r_sda_s1  <= 1'b1;
            r_sda_s2  <= 1'b1;
        end else begin
            r_go_q    <= cmd_go;
            r_go_edge <= cmd_go & ~r_go_q;
            r_sda_s1  <= sda_in;
            r_sda_s2  <= r_sda_s1;
        end
    end

    // State and datapath register.
    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= 2'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_wdata   <= 8'h00;
            r_rw      <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_qcnt    <= w_qcnt_nxt;
            r_phase   <= w_phase_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rw      <= w_rw_nxt;
            r_nack    <= w_nack_nxt;
            r_done    <= w_done_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_scl_oe  <= w_scl_oe_nxt;
        end
    end

    // Next-state, bit timing and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_qcnt_nxt    = r_qcnt;
        w_phase_nxt   = r_phase;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_wdata_nxt   = r_wdata;
        w_rw_nxt      = r_rw;
        w_nack_nxt    = r_nack;
        w_done_nxt    = r_done;
        w_ack_err_nxt = r_ack_err;
        w_rdata_nxt   = r_rdata;

        if (r_state != S_IDLE) begin
            if (w_q_wrap) begin
                w_qcnt_nxt  = '0;
                w_phase_nxt = 2'(r_phase + 2'd1);
            end else begin
                w_qcnt_nxt  = QW'(r_qcnt + QW'(1));
            end
        end

        case (r_state)
            S_IDLE: begin
                if (r_go_edge) begin
                    w_state_nxt   = S_START;
                    w_shift_nxt   = {cmd_addr, cmd_rw};
                    w_wdata_nxt   = cmd_wdata;
                    w_rw_nxt      = cmd_rw;
                    w_nack_nxt    = 1'b0;
                    w_done_nxt    = 1'b0;
                    w_ack_err_nxt = 1'b0;
                    w_qcnt_nxt    = '0;
                    w_phase_nxt   = 2'd0;
                end
            end
            S_START: begin
                if (w_slot_end) begin
                    w_state_nxt  = S_ADDR;
                    w_bitcnt_nxt = 3'd0;
                end
            end
            S_ADDR: begin
                if (w_slot_end) begin
                    w_shift_nxt  = {r_shift[6:0], 1'b0};
                    w_bitcnt_nxt = 3'(r_bitcnt + 3'd1);
                    if (r_bitcnt == 3'd7) w_state_nxt = S_AACK;
                end
            end
            S_AACK: begin
                if (w_sample && r_sda_s2) begin
                    w_nack_nxt    = 1'b1;
                    w_ack_err_nxt = 1'b1;
                end
                if (w_slot_end) begin
                    w_bitcnt_nxt = 3'd0;
                    if (r_nack) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_DATA;
                        if (!r_rw) w_shift_nxt = r_wdata;
                    end
                end
            end
            S_DATA: begin
                if (w_sample && r_rw) w_shift_nxt = {r_shift[6:0], r_sda_s2};
                if (w_slot_end) begin
                    if (!r_rw) w_shift_nxt = {r_shift[6:0], 1'b0};
                    w_bitcnt_nxt = 3'(r_bitcnt + 3'd1);
                    if (r_bitcnt == 3'd7) w_state_nxt = S_DACK;
                end
            end
            S_DACK: begin
                if (w_sample && !r_rw && r_sda_s2) w_ack_err_nxt = 1'b1;
                if (w_slot_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_slot_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    if (r_rw && !r_nack) w_rdata_nxt = r_shift;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_drive      = line_drive(w_state_nxt, w_phase_nxt, ~w_shift_nxt[7], w_rw_nxt);
        w_scl_oe_nxt = w_drive[1];
        w_sda_oe_nxt = w_drive[0];
    end

    assign sda_oe  = r_sda_oe;
    assign scl_oe  = r_scl_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_i2c_wire_master.sv
// Directed bench for i2c_wire_master with an open-drain I2C target model/monitor.
module tb_i2c_wire_master;

    localparam int unsigned CD = 4;

    logic       ti_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_go = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       sda_in;
    logic       sda_oe, scl_oe, busy, done, ack_err;
    logic [7:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    i2c_wire_master #(.CLK_DIV(CD)) dut (
        .ti_clk(ti_clk), .reset_n(reset_n), .cmd_go(cmd_go), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .sda_in(sda_in),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata)
    );

    always #5 ti_clk = ~ti_clk;

    // Target model: wired-AND bus, ACK on request, returns rd_byte on reads.
    logic       slave_pull = 1'b0;
    logic       ack_en = 1'b1;
    logic [7:0] rd_byte = 8'h3C;
    logic       scl_line;
    assign sda_in   = ~(sda_oe | slave_pull);
    assign scl_line = ~scl_oe;

    int         mon_starts = 0, mon_stops = 0, mon_nbytes = 0;
    logic [7:0] mon_bytes[4];
    logic       mon_acks[4];
    int         m_bit = 0, m_idx = 0;
    logic [7:0] m_sh = 8'h00;
    logic       m_rw = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1;

    // Bus monitor and target responder, evaluated on the falling clock edge.
    always @(negedge ti_clk) begin
        if (!reset_n) begin
            slave_pull = 1'b0; m_bit = 0; m_idx = 0; p_scl = 1'b1; p_sda = 1'b1;
        end else begin
            if (scl_line && p_scl && p_sda && !sda_in) begin
                mon_starts++; m_bit = 0; m_idx = 0; mon_nbytes = 0;
            end else if (scl_line && p_scl && !p_sda && sda_in) begin
                mon_stops++;
            end else if (scl_line && !p_scl) begin
                if (m_bit < 8) begin
                    m_sh = {m_sh[6:0], sda_in};
                    m_bit++;
                    if (m_bit == 8) begin
                        if (m_idx < 4) mon_bytes[m_idx] = m_sh;
                        if (m_idx == 0) m_rw = m_sh[0];
                        mon_nbytes++;
                    end
                end else begin
                    if (m_idx < 4) mon_acks[m_idx] = sda_in;
                    m_bit = 0;
                    m_idx++;
                end
            end else if (!scl_line && p_scl) begin
                slave_pull = 1'b0;
                if (m_bit == 8 && ack_en && (m_idx == 0 || (m_idx == 1 && !m_rw)))
                    slave_pull = 1'b1;
                else if (m_bit < 8 && m_idx == 1 && m_rw)
                    slave_pull = ~rd_byte[3'(7 - m_bit)];
            end
            p_scl = scl_line;
            p_sda = sda_in;
        end
    end

    // Counts busy cycles until busy falls; tout set if it never completes.
    task automatic run_txn(input int init, output int bcyc, output bit tout);
        bit fin;
        fin = 1'b0;
        bcyc = init;
        for (int i = 0; i < 4000; i++) begin
            @(negedge ti_clk);
            if (busy) bcyc++;
            else if (bcyc > 0) begin fin = 1'b1; break; end
        end
        tout = !fin;
    endtask

    task automatic start_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        cmd_go = 1'b0;
        @(negedge ti_clk);
        @(negedge ti_clk);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_go = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge ti_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge ti_clk);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_tests++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe got %b want 0", scl_oe); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got %b want 0", ack_err); end
        n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata); end
    endtask

    task automatic test_write();
        int bc, s0, p0; bit to;
        ack_en = 1'b1;
        s0 = mon_starts; p0 = mon_stops;
        start_cmd(1'b0, 7'h50, 8'hA5);
        run_txn(0, bc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL wr_timeout got timeout want completion"); end
        n_tests++; if (bc != 320) begin n_fail++; $display("FAIL wr_busy_cycles got %0d want 320", bc); end
        n_tests++; if (mon_starts - s0 != 1 || mon_stops - p0 != 1) begin n_fail++; $display("FAIL wr_start_stop got %0d/%0d want 1/1", mon_starts - s0, mon_stops - p0); end
        n_tests++; if (mon_nbytes != 2) begin n_fail++; $display("FAIL wr_nbytes got %0d want 2", mon_nbytes); end
        n_tests++; if (mon_bytes[0] !== 8'hA0 || mon_acks[0] !== 1'b0) begin n_fail++; $display("FAIL wr_addr got %h/%b want a0/0", mon_bytes[0], mon_acks[0]); end
        n_tests++; if (mon_bytes[1] !== 8'hA5 || mon_acks[1] !== 1'b0) begin n_fail++; $display("FAIL wr_data got %h/%b want a5/0", mon_bytes[1], mon_acks[1]); end
        n_tests++; if (done !== 1'b1 || ack_err !== 1'b0) begin n_fail++; $display("FAIL wr_status got done=%b ack_err=%b want 1/0", done, ack_err); end
    endtask

    task automatic test_read();
        int bc, p0; bit to;
        ack_en = 1'b1; rd_byte = 8'h3C;
        p0 = mon_stops;
        start_cmd(1'b1, 7'h50, 8'hFF);
        run_txn(0, bc, to);
        n_tests++; if (to || bc != 320) begin n_fail++; $display("FAIL rd_busy_cycles got %0d (timeout %b) want 320", bc, to); end
        n_tests++; if (mon_bytes[0] !== 8'hA1 || mon_acks[0] !== 1'b0) begin n_fail++; $display("FAIL rd_addr got %h/%b want a1/0", mon_bytes[0], mon_acks[0]); end
        n_tests++; if (mon_bytes[1] !== 8'h3C || mon_acks[1] !== 1'b1) begin n_fail++; $display("FAIL rd_data_nack got %h/%b want 3c/1", mon_bytes[1], mon_acks[1]); end
        n_tests++; if (mon_stops - p0 != 1) begin n_fail++; $display("FAIL rd_stop got %0d want 1", mon_stops - p0); end
        n_tests++; if (rdata !== 8'h3C || done !== 1'b1 || ack_err !== 1'b0) begin n_fail++; $display("FAIL rd_status got rdata=%h done=%b ack_err=%b want 3c/1/0", rdata, done, ack_err); end
    endtask

    task automatic test_addr_nack();
        int bc, p0; bit to;
        ack_en = 1'b0; rd_byte = 8'h99;
        p0 = mon_stops;
        start_cmd(1'b1, 7'h50, 8'h00);
        run_txn(0, bc, to);
        n_tests++; if (to || bc != 176) begin n_fail++; $display("FAIL nack_busy_cycles got %0d (timeout %b) want 176", bc, to); end
        n_tests++; if (mon_nbytes != 1 || mon_bytes[0] !== 8'hA1 || mon_acks[0] !== 1'b1) begin n_fail++; $display("FAIL nack_bus got n=%0d %h/%b want 1 a1/1", mon_nbytes, mon_bytes[0], mon_acks[0]); end
        n_tests++; if (mon_stops - p0 != 1) begin n_fail++; $display("FAIL nack_stop got %0d want 1", mon_stops - p0); end
        n_tests++; if (ack_err !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL nack_status got ack_err=%b done=%b want 1/1", ack_err, done); end
        n_tests++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL nack_rdata got %h want 3c", rdata); end
        ack_en = 1'b1; rd_byte = 8'h3C;
    endtask

    task automatic test_go_while_busy();
        int s0, rises; logic pd;
        s0 = mon_starts; rises = 0;
        start_cmd(1'b0, 7'h21, 8'hA5);
        pd = done;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ti_clk);
            if (i == 100) begin cmd_go = 1'b0; cmd_wdata = 8'h00; end
            if (i == 105) cmd_go = 1'b1;
            if (done && !pd) rises++;
            pd = done;
        end
        n_tests++; if (mon_starts - s0 != 1) begin n_fail++; $display("FAIL gwb_starts got %0d want 1", mon_starts - s0); end
        n_tests++; if (rises != 1) begin n_fail++; $display("FAIL gwb_done_rises got %0d want 1", rises); end
        n_tests++; if (mon_bytes[0] !== 8'h42 || mon_bytes[1] !== 8'hA5) begin n_fail++; $display("FAIL gwb_bytes got %h %h want 42 a5", mon_bytes[0], mon_bytes[1]); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gwb_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_level_hold();
        int bc, s0, seen; bit to;
        ack_en = 1'b0;
        start_cmd(1'b0, 7'h33, 8'h11);
        run_txn(0, bc, to);
        n_tests++; if (to || ack_err !== 1'b1) begin n_fail++; $display("FAIL lh_setup got ack_err=%b timeout=%b want 1/0", ack_err, to); end
        ack_en = 1'b1;
        s0 = mon_starts; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ti_clk);
            if (busy) seen++;
        end
        n_tests++; if (seen != 0 || mon_starts != s0) begin n_fail++; $display("FAIL lh_no_retrigger got busy_cycles=%0d starts=%0d want 0/0", seen, mon_starts - s0); end
        start_cmd(1'b0, 7'h33, 8'h11);
        @(negedge ti_clk);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL lh_edge_plus1 got done=%b busy=%b want 1/0", done, busy); end
        @(negedge ti_clk);
        n_tests++; if (done !== 1'b0 || ack_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lh_edge_plus2 got done=%b ack_err=%b busy=%b want 0/0/1", done, ack_err, busy); end
        run_txn(1, bc, to);
        n_tests++; if (to || bc != 320 || done !== 1'b1 || ack_err !== 1'b0) begin n_fail++; $display("FAIL lh_txn got cycles=%0d done=%b ack_err=%b want 320/1/0", bc, done, ack_err); end
    endtask

    task automatic test_reset_mid();
        int bc; bit to, hit;
        start_cmd(1'b0, 7'h50, 8'h5A);
        repeat (215) @(negedge ti_clk);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (scl_oe) begin hit = 1'b1; break; end
            @(negedge ti_clk);
        end
        n_tests++; if (!hit || busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre got busy=%b scl_low_seen=%b want 1/1", busy, hit); end
        reset_n = 1'b0; cmd_go = 1'b0;
        #1;
        n_tests++; if (sda_oe !== 1'b0 || scl_oe !== 1'b0) begin n_fail++; $display("FAIL rm_lines got sda_oe=%b scl_oe=%b want 0/0", sda_oe, scl_oe); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL rm_status got busy=%b done=%b ack_err=%b rdata=%h want 0/0/0/00", busy, done, ack_err, rdata); end
        repeat (3) @(negedge ti_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge ti_clk);
        start_cmd(1'b0, 7'h50, 8'h5A);
        run_txn(0, bc, to);
        n_tests++; if (to || bc != 320 || done !== 1'b1) begin n_fail++; $display("FAIL rm_after got cycles=%0d done=%b want 320/1", bc, done); end
        n_tests++; if (mon_bytes[0] !== 8'hA0 || mon_bytes[1] !== 8'h5A) begin n_fail++; $display("FAIL rm_bytes got %h %h want a0 5a", mon_bytes[0], mon_bytes[1]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_go_while_busy();
        test_level_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
